// File: rtl/usb_rx_pkg.sv
// Shared constants and state encoding for the USB receive front end.
// Bit timing assumes an 8x oversampling clock.
package usb_rx_pkg;

   localparam int CLKS_PER_BIT = 8;
   localparam int CNT_W = $clog2(CLKS_PER_BIT);
   localparam logic [CNT_W-1:0] SAMPLE_POINT = CNT_W'(3);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RECEIVE,
      ST_EOP_WAIT
   } rx_state_e;

endpackage

// File: rtl/usb_sync.sv
// Two-flop synchronizer for one asynchronous line.
// RST_VAL sets the idle level both flops take on reset.
module usb_sync #(
   parameter logic RST_VAL = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= RST_VAL;
         q    <= RST_VAL;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/usb_rx_bit_timer.sv
// USB full-speed receive bit timer: recovers bit timing from D+ edges,
// NRZI-decodes each sampled bit and flags end-of-packet.
module usb_rx_bit_timer
   import usb_rx_pkg::*;
(
   input  logic clk,
   input  logic rst,
   input  logic d_plus,
   input  logic d_minus,
   output logic shift_en,
   output logic d_orig,
   output logic eop,
   output logic rcving
);

   logic             dp_s;
   logic             dm_s;
   logic             dp_d;
   logic [CNT_W-1:0] count;
   rx_state_e        state;
   rx_state_e        state_nx;
   logic             prev_bit;
   logic             prev_nx;
   logic             d_hold;
   logic             edge_det;
   logic             sample;
   logic             se0;

   usb_sync #(.RST_VAL(1'b1)) u_sync_dp (
      .clk (clk),
      .rst (rst),
      .d   (d_plus),
      .q   (dp_s)
   );

   usb_sync #(.RST_VAL(1'b0)) u_sync_dm (
      .clk (clk),
      .rst (rst),
      .d   (d_minus),
      .q   (dm_s)
   );

   // An edge re-centres the bit window, so it also suppresses a sample.
   assign edge_det = dp_s ^ dp_d;
   assign sample   = ~edge_det & (count == SAMPLE_POINT);
   assign se0      = ~dp_s & ~dm_s;

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= ST_IDLE;
         count    <= '0;
         prev_bit <= 1'b1;
         dp_d     <= 1'b1;
         d_hold   <= 1'b1;
      end else begin
         state    <= state_nx;
         count    <= edge_det ? '0 : count + 1'b1;
         prev_bit <= prev_nx;
         dp_d     <= dp_s;
         d_hold   <= d_orig;
      end
   end

   always_comb begin
      state_nx = state;
      prev_nx  = prev_bit;
      shift_en = 1'b0;
      eop      = 1'b0;
      rcving   = 1'b0;
      d_orig   = d_hold;
      unique case (state)
         ST_IDLE: begin
            if (edge_det & ~dp_s & dm_s)
               state_nx = ST_RECEIVE;
         end
         ST_RECEIVE: begin
            rcving = 1'b1;
            if (sample) begin
               if (se0) begin
                  eop      = 1'b1;
                  state_nx = ST_EOP_WAIT;
               end else begin
                  shift_en = 1'b1;
                  d_orig   = ~(dp_s ^ prev_bit);
                  prev_nx  = dp_s;
               end
            end
         end
         ST_EOP_WAIT: begin
            rcving = 1'b1;
            if (sample & ~se0) begin
               state_nx = ST_IDLE;
               prev_nx  = 1'b1;
            end
         end
         default: state_nx = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_usb_rx_bit_timer.sv
// Bench for usb_rx_bit_timer: timing/decoding model plus directed packets.
module tb_usb_rx_bit_timer;

   localparam int N = 16384;
   localparam string SYNC = "KJKJKJKK";

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic d_plus = 1'b1;
   logic d_minus = 1'b0;
   logic shift_en;
   logic d_orig;
   logic eop;
   logic rcving;

   int tests = 0;
   int fails = 0;
   int cyc = 0;

   logic cap_dp [N];
   logic cap_dm [N];

   int   se_cyc [$];
   int   se_bit [$];
   int   eop_cyc [$];

   typedef enum logic [1:0] {M_IDLE, M_RX, M_EW} mst_t;

   always #5 clk = ~clk;

   usb_rx_bit_timer dut (
      .clk      (clk),
      .rst      (rst),
      .d_plus   (d_plus),
      .d_minus  (d_minus),
      .shift_en (shift_en),
      .d_orig   (d_orig),
      .eop      (eop),
      .rcving   (rcving)
   );

   task automatic check(string nm, int act, int exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
      end
   endtask

   // Model: after a D+ change captured at edge E, samples fall at E+5+8n
   // until the next change becomes visible; line seen = capture one cycle back.
   initial begin
      int   c;
      int   elast;
      logic r, dps, dms, edg, smp;
      logic prev, dorig;
      logic e_se, e_eop, e_rcv;
      mst_t st;
      elast = -100;
      st = M_IDLE;
      prev = 1'b1;
      dorig = 1'b1;
      forever begin
         @(posedge clk);
         cyc++;
         c = cyc;
         r = rst;
         cap_dp[c] = d_plus;
         cap_dm[c] = d_minus;
         #1;
         e_se = 1'b0;
         e_eop = 1'b0;
         e_rcv = 1'b0;
         if (r) begin
            st = M_IDLE;
            prev = 1'b1;
            dorig = 1'b1;
            cap_dp[c] = 1'b1;
            cap_dm[c] = 1'b0;
            cap_dp[c-1] = 1'b1;
            cap_dm[c-1] = 1'b0;
         end else begin
            dps = cap_dp[c-1];
            dms = cap_dm[c-1];
            edg = cap_dp[c-1] != cap_dp[c-2];
            e_rcv = st != M_IDLE;
            smp = (st != M_IDLE) && !edg && ((c - elast) % 8 == 5);
            if (st == M_IDLE) begin
               if (edg && !dps && dms) begin
                  st = M_RX;
                  elast = c - 1;
               end
            end else begin
               if (edg) elast = c - 1;
               if (smp) begin
                  if (!dps && !dms) begin
                     if (st == M_RX) begin
                        e_eop = 1'b1;
                        st = M_EW;
                     end
                  end else if (st == M_RX) begin
                     e_se = 1'b1;
                     dorig = dps == prev;
                     prev = dps;
                  end else begin
                     st = M_IDLE;
                     prev = 1'b1;
                  end
               end
            end
         end
         check($sformatf("cyc%0d {se,eop,rcv,dorig}", c),
               int'({shift_en, eop, rcving, d_orig}),
               int'({e_se, e_eop, e_rcv, dorig}));
         if (shift_en) begin
            se_cyc.push_back(c);
            se_bit.push_back(int'(d_orig));
         end
         if (eop) eop_cyc.push_back(c);
      end
   end

   task automatic sym(byte s, int n);
      case (s)
         "K":     begin d_plus = 1'b0; d_minus = 1'b1; end
         "0":     begin d_plus = 1'b0; d_minus = 1'b0; end
         default: begin d_plus = 1'b1; d_minus = 1'b0; end
      endcase
      repeat (n) @(negedge clk);
   endtask

   task automatic send(string s, int n);
      for (int i = 0; i < s.len(); i++) sym(s[i], n);
   endtask

   initial begin
      int b, e0, ne;
      @(negedge clk);
      repeat (3) @(negedge clk);
      rst = 1'b0;

      // idle J after reset
      b = se_cyc.size();
      ne = eop_cyc.size();
      repeat (100) @(negedge clk);
      check("idle shift_en count", se_cyc.size() - b, 0);
      check("idle eop count", eop_cyc.size() - ne, 0);
      check("idle rcving", int'(rcving), 0);
      check("idle d_orig", int'(d_orig), 1);

      // SYNC at 8 clk/bit, short payload, 2-bit SE0, J
      b = se_cyc.size();
      ne = eop_cyc.size();
      e0 = cyc + 1;
      send(SYNC, 8);
      check("rcving in packet", int'(rcving), 1);
      send("JKKJ", 8);
      send("00", 8);
      send("JJJ", 8);
      for (int n = 0; n < 8; n++) begin
         check($sformatf("sync cycle %0d", n), se_cyc[b+n] - e0, 5 + 8 * n);
         check($sformatf("sync bit %0d", n), se_bit[b+n], n == 7 ? 1 : 0);
      end
      check("payload bit0", se_bit[b+8], 0);
      check("payload bit2", se_bit[b+10], 1);
      check("pkt1 shift count", se_cyc.size() - b, 12);
      check("pkt1 eop count", eop_cyc.size() - ne, 1);
      check("pkt1 eop cycle", eop_cyc[ne] - e0, 101);
      check("pkt1 rcving after J", int'(rcving), 0);

      // 7 clk/bit then 9 clk/bit
      b = se_cyc.size();
      ne = eop_cyc.size();
      send(SYNC, 8);
      send("KJJKJKKJ", 7);
      send("KKJKJJKJ", 9);
      send("00", 8);
      send("JJ", 8);
      check("jitter shift count", se_cyc.size() - b, 24);
      check("jitter eop count", eop_cyc.size() - ne, 1);

      // eight identical K then a stuffed J
      b = se_cyc.size();
      send(SYNC, 8);
      send("KKKKKKKK", 8);
      send("J", 8);
      send("00", 8);
      send("JJ", 8);
      for (int n = 0; n < 8; n++)
         check($sformatf("run K bit %0d", n), se_bit[b+8+n], 1);
      check("stuffed bit", se_bit[b+16], 0);
      check("run shift count", se_cyc.size() - b, 17);

      // reset during third data bit
      send(SYNC, 8);
      send("JK", 8);
      sym("K", 3);
      rst = 1'b1;
      d_plus = 1'b1;
      d_minus = 1'b0;
      @(negedge clk);
      check("rst outs {se,eop,rcv,dorig}",
            int'({shift_en, eop, rcving, d_orig}), 4'b0001);
      @(negedge clk);
      rst = 1'b0;
      b = se_cyc.size();
      ne = eop_cyc.size();
      send("JJ", 8);
      check("post-rst shift count", se_cyc.size() - b, 0);
      check("post-rst eop count", eop_cyc.size() - ne, 0);
      b = se_cyc.size();
      send(SYNC, 8);
      send("00", 8);
      send("JJ", 8);
      check("resync count", se_cyc.size() - b, 8);
      check("resync bit0", se_bit[b], 0);
      check("resync bit7", se_bit[b+7], 1);
      check("resync eop count", eop_cyc.size() - ne, 1);

      repeat (4) @(negedge clk);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
